// File: rtl/fetch_stage.sv
// Purpose : instruction fetch stage; drives imem with the PC and fills the IF/ID latch.
// Latency : word accepted with imem_ready=1 at edge N appears on if_instr/if_valid after edge N.
// Backpr. : stall holds PC and the IF/ID latch and drops imem_req; br_taken overrides stall.
//
// Ports:
//   CLK, RSTN              clock, asynchronous active-low reset
//   stall                  decode cannot accept; hold the IF/ID latch
//   br_taken, br_target    redirect from execute; flushes the latch and loads the PC
//   imem_req, imem_addr    instruction memory read request and word address (= PC)
//   imem_rdata, imem_ready returned instruction word and its strobe
//   if_pc, if_instr,       IF/ID latch contents
//   if_valid
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] HALT_OPCODE = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= 16'h0000;
      if_instr_q <= 16'h0000;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    imem_req   = 1'b0;

    case (state_q)
      ST_BOOT: begin
        // One idle cycle after reset; redirects are not honoured here.
        if_valid_d = 1'b0;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        imem_req = !stall && !br_taken;
        if (br_taken) begin
          // Only the latched word is discarded; its pc/instr stay visible.
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; a returned word is ignored and refetched later.
        end else if (imem_ready) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + 16'h0001;
          if (imem_rdata == HALT_OPCODE) begin
            state_d = ST_HALT;
          end
        end else begin
          if_valid_d = 1'b0;
        end
      end

      ST_HALT: begin
        if (br_taken) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
          state_d    = ST_RUN;
        end else if (!stall) begin
          // Let decode consume the halt word, then go quiet.
          if_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign imem_addr = pc_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

endmodule
